// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send,
// shifts one byte out on device-generated clocks and checks the device ACK.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | bus released, ready for a new byte
// ST_INHIBIT   | PS/2 clock held low for INHIBIT_CYCLES
// ST_RTS       | clock and data both low for one cycle (start bit)
// ST_XFER      | clock released, data driven per device falling edge
// ST_WAIT_IDLE | ACK sampled, waiting for clock and data to return high
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES      = 1478,
   parameter int unsigned FIRST_EDGE_CYCLES   = 221700,
   parameter int unsigned EDGE_TIMEOUT_CYCLES = 29560,
   parameter int unsigned FILTER_LEN          = 4
) (
   input  logic       clk_i,
   input  logic       reset_n,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       busy_o,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe_o,
   output logic       ps2_data_oe_o,
   output logic       done_o,
   output logic       ack_err_o,
   output logic       timeout_o
);

   localparam int unsigned WD_W  = $clog2(FIRST_EDGE_CYCLES + 1);
   localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);

   localparam logic [WD_W-1:0]  WD_FIRST_TC = WD_W'(FIRST_EDGE_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_EDGE_TC  = WD_W'(EDGE_TIMEOUT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_LOAD    = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [FLT_W-1:0] FLT_TC      = FLT_W'(FILTER_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_XFER,
      ST_WAIT_IDLE
   } state_t;

   state_t           state_q, state_d;
   logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic             clk_filt_q, clk_filt_d;
   logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
   logic             fall_q, fall_d;
   logic [INH_W-1:0] inh_q, inh_d;
   logic [WD_W-1:0]  wd_q, wd_d, wd_inc;
   logic [3:0]       n_q, n_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic             ack_err_q, ack_err_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic             clk_oe_q, clk_oe_d;
   logic             data_oe_q, data_oe_d;

   // Two-flop synchronizers; idle bus level is high.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= ps2_clk_i;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= ps2_data_i;
         dat_s2_q <= dat_s1_q;
      end
   end

   // Clock filter: level flips after FILTER_LEN consecutive differing samples.
   always_comb begin
      flt_cnt_d  = '0;
      clk_filt_d = clk_filt_q;
      if (clk_s2_q != clk_filt_q) begin
         if (flt_cnt_q == FLT_TC) begin
            clk_filt_d = clk_s2_q;
         end else begin
            flt_cnt_d = flt_cnt_q + 1'b1;
         end
      end
      fall_d = clk_filt_q & ~clk_filt_d;
   end

   // Sequencer next-state, counters and registered open-drain enables.
   always_comb begin
      state_d   = state_q;
      inh_d     = inh_q;
      wd_inc    = (wd_q == '1) ? wd_q : wd_q + 1'b1;
      wd_d      = wd_inc;
      n_d       = n_q;
      shift_d   = shift_q;
      par_d     = par_q;
      ack_err_d = ack_err_q;
      done_d    = 1'b0;
      timeout_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            wd_d = '0;
            if (tx_valid_i) begin
               shift_d = tx_data_i;
               par_d   = ~^tx_data_i;
               inh_d   = INH_LOAD;
               state_d = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            wd_d = '0;
            if (inh_q == '0) begin
               state_d = ST_RTS;
            end else begin
               inh_d = inh_q - 1'b1;
            end
         end
         ST_RTS: begin
            wd_d    = '0;
            n_d     = '0;
            state_d = ST_XFER;
         end
         ST_XFER: begin
            if (fall_q) begin
               wd_d = '0;
               n_d  = n_q + 1'b1;
               if (n_q == 4'd10) begin
                  ack_err_d = dat_s2_q;
                  state_d   = ST_WAIT_IDLE;
               end
            end else if (wd_q == ((n_q == 4'd0) ? WD_FIRST_TC : WD_EDGE_TC)) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            if (clk_filt_q && dat_s2_q) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (wd_q == WD_EDGE_TC) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Enables follow the next state so the pins are glitch-free flop outputs.
      clk_oe_d  = (state_d == ST_INHIBIT) || (state_d == ST_RTS);
      data_oe_d = 1'b0;
      if (state_d == ST_RTS) begin
         data_oe_d = 1'b1;
      end else if (state_d == ST_XFER) begin
         if (n_d == 4'd0) begin
            data_oe_d = 1'b1;
         end else if (n_d <= 4'd8) begin
            data_oe_d = ~shift_d[3'(n_d - 4'd1)];
         end else if (n_d == 4'd9) begin
            data_oe_d = ~par_d;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         clk_filt_q <= 1'b1;
         flt_cnt_q  <= '0;
         fall_q     <= 1'b0;
         inh_q      <= '0;
         wd_q       <= '0;
         n_q        <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         ack_err_q  <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         clk_oe_q   <= 1'b0;
         data_oe_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         clk_filt_q <= clk_filt_d;
         flt_cnt_q  <= flt_cnt_d;
         fall_q     <= fall_d;
         inh_q      <= inh_d;
         wd_q       <= wd_d;
         n_q        <= n_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         ack_err_q  <= ack_err_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
         clk_oe_q   <= clk_oe_d;
         data_oe_q  <= data_oe_d;
      end
   end

   assign tx_ready_o    = (state_q == ST_IDLE);
   assign busy_o        = ~tx_ready_o;
   assign ps2_clk_oe_o  = clk_oe_q;
   assign ps2_data_oe_o = data_oe_q;
   assign done_o        = done_q;
   assign ack_err_o     = done_q & ack_err_q;
   assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: keyboard model on a wired-AND bus, frames checked
// against bytes rebuilt from the PS/2 framing rules.
module tb_ps2_host_tx;

   localparam int INH   = 40;
   localparam int FIRST = 600;
   localparam int EDGE  = 200;
   localparam int HALF  = 20;

   logic       clk_i = 1'b0;
   logic       reset_n;
   logic [7:0] tx_data_i;
   logic       tx_valid_i;
   logic       tx_ready_o, busy_o;
   logic       ps2_clk_oe_o, ps2_data_oe_o;
   logic       done_o, ack_err_o, timeout_o;
   logic       dev_clk, dev_data;
   logic       ps2_clk_i, ps2_data_i;

   assign ps2_clk_i  = ~ps2_clk_oe_o & dev_clk;
   assign ps2_data_i = ~ps2_data_oe_o & dev_data;

   ps2_host_tx #(
      .INHIBIT_CYCLES     (INH),
      .FIRST_EDGE_CYCLES  (FIRST),
      .EDGE_TIMEOUT_CYCLES(EDGE),
      .FILTER_LEN         (4)
   ) dut (
      .clk_i        (clk_i),
      .reset_n      (reset_n),
      .tx_data_i    (tx_data_i),
      .tx_valid_i   (tx_valid_i),
      .tx_ready_o   (tx_ready_o),
      .busy_o       (busy_o),
      .ps2_clk_i    (ps2_clk_i),
      .ps2_data_i   (ps2_data_i),
      .ps2_clk_oe_o (ps2_clk_oe_o),
      .ps2_data_oe_o(ps2_data_oe_o),
      .done_o       (done_o),
      .ack_err_o    (ack_err_o),
      .timeout_o    (timeout_o)
   );

   // 10-unit system clock.
   always #5 clk_i = ~clk_i;

   int   n_pass = 0, n_total = 0;
   int   cyc = 0, done_cnt = 0, to_cnt = 0, start_cnt = 0;
   int   to_cyc = 0, rel_cyc = 0, last_fall_cyc = 0;
   logic last_ack = 1'b0;
   logic prev_clk_oe = 1'b0;

   // Event monitor sampled mid-cycle.
   always @(negedge clk_i) begin
      cyc = cyc + 1;
      if (done_o === 1'b1) begin
         done_cnt = done_cnt + 1;
         last_ack = ack_err_o;
      end
      if (timeout_o === 1'b1) begin
         to_cnt = to_cnt + 1;
         to_cyc = cyc;
      end
      if (ps2_clk_oe_o === 1'b1 && prev_clk_oe === 1'b0) start_cnt = start_cnt + 1;
      if (ps2_clk_oe_o === 1'b0 && prev_clk_oe === 1'b1 && busy_o === 1'b1) rel_cyc = cyc;
      prev_clk_oe = ps2_clk_oe_o;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference frame as seen by the device at its rising edges: 8 data bits
   // LSB first, odd parity, stop bit high.
   function automatic logic [9:0] exp_frame(input logic [7:0] b);
      logic par;
      par = (($countones(b) % 2) == 0);
      return {1'b1, par, b};
   endfunction

   task automatic send_byte(input logic [7:0] b);
      int w = 0;
      while (tx_ready_o !== 1'b1 && w < 5000) begin
         @(negedge clk_i);
         w++;
      end
      chk("ready_before_send", tx_ready_o, 1'b1);
      tx_data_i  = b;
      tx_valid_i = 1'b1;
      @(negedge clk_i);
      tx_valid_i = 1'b0;
   endtask

   // Keyboard model: waits for the request-to-send, then clocks n_edges.
   task automatic kbd(input int n_edges, input bit ack, input int glitch_after,
                      output logic [9:0] got, output bit ok);
      int w = 0;
      got = '0;
      while (!(ps2_clk_oe_o === 1'b0 && ps2_data_oe_o === 1'b1 && busy_o === 1'b1)
             && w < INH + 100) begin
         @(negedge clk_i);
         w++;
      end
      ok = (ps2_clk_oe_o === 1'b0 && ps2_data_oe_o === 1'b1 && busy_o === 1'b1);
      repeat (10) @(negedge clk_i);
      for (int e = 1; e <= n_edges; e++) begin
         if (e == 11) begin
            dev_data = ack ? 1'b0 : 1'b1;
            repeat (3) @(negedge clk_i);
         end
         dev_clk       = 1'b0;
         last_fall_cyc = cyc;
         repeat (HALF) @(negedge clk_i);
         if (e <= 10) got[e-1] = ps2_data_i;
         dev_clk = 1'b1;
         if (e == glitch_after) begin
            repeat (5) @(negedge clk_i);
            dev_clk = 1'b0;
            repeat (2) @(negedge clk_i);
            dev_clk = 1'b1;
            repeat (HALF - 7) @(negedge clk_i);
         end else begin
            repeat (HALF) @(negedge clk_i);
         end
      end
      dev_data = 1'b1;
   endtask

   task automatic wait_event(input int snap);
      int w = 0;
      while (done_cnt + to_cnt == snap && w < 3000) begin
         @(posedge clk_i);
         w++;
      end
   endtask

   task automatic full_frame(input logic [7:0] b, input bit ack, input int glitch_after,
                             input bit chk_inh, input bit busy_poke, input string tag);
      logic [9:0] got;
      bit         ok;
      int         snap_d, snap_t, cnt;
      snap_d = done_cnt;
      snap_t = to_cnt;
      send_byte(b);
      if (chk_inh) begin
         cnt = 0;
         while (ps2_clk_oe_o === 1'b1 && ps2_data_oe_o === 1'b0 && cnt < 1000) begin
            cnt++;
            @(negedge clk_i);
         end
         chk({tag, "_inhibit_len"}, cnt, INH);
         chk({tag, "_rts"}, {ps2_clk_oe_o, ps2_data_oe_o}, 2'b11);
         @(negedge clk_i);
         chk({tag, "_release"}, {ps2_clk_oe_o, ps2_data_oe_o}, 2'b01);
      end
      if (busy_poke) begin
         repeat (3) @(negedge clk_i);
         chk({tag, "_busy"}, busy_o, 1'b1);
         tx_data_i  = 8'hAA;
         tx_valid_i = 1'b1;
         @(negedge clk_i);
         tx_valid_i = 1'b0;
      end
      kbd(11, ack, glitch_after, got, ok);
      chk({tag, "_rts_seen"}, ok, 1'b1);
      chk({tag, "_bits"}, got, exp_frame(b));
      wait_event(snap_d + snap_t);
      @(posedge clk_i);
      chk({tag, "_done"}, done_cnt - snap_d, 1);
      chk({tag, "_ack_err"}, last_ack, ack ? 1'b0 : 1'b1);
      chk({tag, "_no_timeout"}, to_cnt - snap_t, 0);
   endtask

   initial begin
      logic [9:0] got;
      bit         ok;
      int         snap, starts, d;
      logic [7:0] rb;
      bit         ra;

      reset_n    = 1'b0;
      tx_valid_i = 1'b0;
      tx_data_i  = '0;
      dev_clk    = 1'b1;
      dev_data   = 1'b1;
      repeat (5) @(negedge clk_i);
      chk("reset_outputs",
          {tx_ready_o, busy_o, ps2_clk_oe_o, ps2_data_oe_o, done_o, ack_err_o, timeout_o},
          7'b1000000);
      reset_n = 1'b1;
      repeat (5) @(negedge clk_i);

      full_frame(8'hED, 1'b1, 0, 1'b1, 1'b0, "ed");

      starts = start_cnt;
      full_frame(8'h00, 1'b1, 0, 1'b0, 1'b1, "b2b_00");
      full_frame(8'hFF, 1'b1, 0, 1'b0, 1'b1, "b2b_ff");
      full_frame(8'h07, 1'b1, 0, 1'b0, 1'b1, "b2b_07");
      repeat (100) @(negedge clk_i);
      chk("no_extra_frame", start_cnt - starts, 3);
      chk("idle_after_b2b", {tx_ready_o, ps2_clk_oe_o}, 2'b10);

      full_frame(8'h5A, 1'b0, 0, 1'b0, 1'b0, "nak");

      snap = done_cnt + to_cnt;
      d    = done_cnt;
      send_byte(8'h55);
      wait_event(snap);
      chk("first_timeout_cycles", to_cyc - rel_cyc, FIRST);
      @(negedge clk_i);
      chk("first_timeout_idle", {ps2_clk_oe_o, ps2_data_oe_o, tx_ready_o}, 3'b001);
      chk("first_timeout_no_done", done_cnt - d, 0);

      snap = done_cnt + to_cnt;
      d    = done_cnt;
      send_byte(8'h3C);
      kbd(5, 1'b1, 0, got, ok);
      chk("edge5_rts_seen", ok, 1'b1);
      wait_event(snap);
      chk("edge5_timeout_late", (to_cyc - last_fall_cyc) >= EDGE + 3, 1'b1);
      chk("edge5_timeout_early", (to_cyc - last_fall_cyc) <= EDGE + 10, 1'b1);
      chk("edge5_no_done", done_cnt - d, 0);
      full_frame(8'hF4, 1'b1, 0, 1'b0, 1'b0, "f4");

      full_frame(8'hC3, 1'b1, 4, 1'b0, 1'b0, "glitch");

      for (int i = 0; i < 4; i++) begin
         rb = 8'($urandom);
         ra = 1'($urandom_range(0, 1));
         full_frame(rb, ra, 0, 1'b0, 1'b0, "rand");
      end

      send_byte(8'h00);
      kbd(3, 1'b1, 0, got, ok);
      chk("rst_pre_oe", {ps2_clk_oe_o, ps2_data_oe_o}, 2'b01);
      #2 reset_n = 1'b0;
      #1 chk("rst_async_oe", {ps2_clk_oe_o, ps2_data_oe_o, tx_ready_o}, 3'b001);
      @(negedge clk_i);
      reset_n = 1'b1;
      repeat (5) @(negedge clk_i);
      chk("rst_release_ready", {tx_ready_o, busy_o}, 2'b10);
      full_frame(8'hA7, 1'b1, 0, 1'b0, 1'b0, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
